fsm_shuffler: RTL and testbench

//  RC4 key-scheduling shuffle (KSA phase 2) over a 256x8 S-box RAM already initialised to S[k]=k.
//  For i=0..255: j=(j+S[i]+key[i mod 3]) mod 256, then swap S[i] and S[j].

---
 rtl/rc4_pkg.sv | 23 ++
 rtl/fsm_shuffler_if.sv | 24 ++
 rtl/fsm_shuffler.sv | 119 +++++++++++
 tb/tb_fsm_shuffler.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/rc4_pkg.sv
// Shared types and constants for the RC4 key-scheduling shuffle.
package rc4_pkg;

  localparam int KEY_LEN    = 3;
  localparam int SBOX_DEPTH = 256;
  localparam int BYTE_W     = 8;

  typedef logic [BYTE_W-1:0] byte_t;

  typedef logic [3:0] state_t;
  localparam state_t ST_IDLE = 4'd0;
  localparam state_t ST_RD_I = 4'd1;
  localparam state_t ST_WT_I = 4'd2;
  localparam state_t ST_LT_I = 4'd3;
  localparam state_t ST_RD_J = 4'd4;
  localparam state_t ST_WT_J = 4'd5;
  localparam state_t ST_LT_J = 4'd6;
  localparam state_t ST_WR_I = 4'd7;
  localparam state_t ST_WR_J = 4'd8;
  localparam state_t ST_NXT  = 4'd9;
  localparam state_t ST_DONE = 4'd10;

endpackage

// File: rtl/fsm_shuffler_if.sv
// Start/finish handshake and single-port S-box RAM bus of the shuffler.
interface fsm_shuffler_if;
  import rc4_pkg::*;

  logic [23:0] Secret_Key;
  logic        In_Start;
  byte_t       q;
  logic        Finish_ack;
  byte_t       data;
  byte_t       Address;
  logic        Init_Finish;
  logic        wren;

  modport master (
    input  Secret_Key, In_Start, q, Finish_ack,
    output data, Address, Init_Finish, wren
  );

  modport slave (
    output Secret_Key, In_Start, q, Finish_ack,
    input  data, Address, Init_Finish, wren
  );

endinterface

// File: rtl/fsm_shuffler.sv
// RC4 KSA swap loop over a pre-initialised 256x8 S-box in single-port sync RAM.
// state | meaning
// IDLE  | wait for In_Start
// RD_I  | put i on the address bus
// WT_I  | RAM read latency
// LT_I  | latch S[i], update j
// RD_J  | put j on the address bus
// WT_J  | RAM read latency
// LT_J  | latch S[j]
// WR_I  | write S[j] to i
// WR_J  | write S[i] to j
// NXT   | end of iteration, advance i
// DONE  | hold Init_Finish until Finish_ack
module fsm_shuffler
  import rc4_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  fsm_shuffler_if.master bus
);

  state_t     state;
  byte_t      i, j, si, sj;
  byte_t      addr_r, data_r;
  logic       wren_r, finish_r;
  logic [1:0] kidx;
  byte_t      key_byte;

  always_comb begin
    case (kidx)
      2'd0:    key_byte = bus.Secret_Key[23:16];
      2'd1:    key_byte = bus.Secret_Key[15:8];
      default: key_byte = bus.Secret_Key[7:0];
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      i        <= '0;
      j        <= '0;
      si       <= '0;
      sj       <= '0;
      kidx     <= '0;
      addr_r   <= '0;
      data_r   <= '0;
      wren_r   <= 1'b0;
      finish_r <= 1'b0;
    end else begin
      wren_r <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.In_Start) begin
            i     <= '0;
            j     <= '0;
            kidx  <= '0;
            state <= ST_RD_I;
          end
        end
        ST_RD_I: begin
          addr_r <= i;
          state  <= ST_WT_I;
        end
        ST_WT_I: state <= ST_LT_I;
        ST_LT_I: begin
          si    <= bus.q;
          j     <= j + bus.q + key_byte;
          state <= ST_RD_J;
        end
        ST_RD_J: begin
          addr_r <= j;
          state  <= ST_WT_J;
        end
        ST_WT_J: state <= ST_LT_J;
        ST_LT_J: begin
          sj    <= bus.q;
          state <= ST_WR_I;
        end
        ST_WR_I: begin
          addr_r <= i;
          data_r <= sj;
          wren_r <= 1'b1;
          state  <= ST_WR_J;
        end
        ST_WR_J: begin
          addr_r <= j;
          data_r <= si;
          wren_r <= 1'b1;
          state  <= ST_NXT;
        end
        ST_NXT: begin
          if (i == 8'(SBOX_DEPTH - 1)) begin
            state <= ST_DONE;
          end else begin
            i     <= i + 8'd1;
            // key index wraps at KEY_LEN instead of computing i mod 3
            kidx  <= (kidx == 2'(KEY_LEN - 1)) ? 2'd0 : kidx + 2'd1;
            state <= ST_RD_I;
          end
        end
        ST_DONE: begin
          if (bus.Finish_ack) begin
            finish_r <= 1'b0;
            state    <= ST_IDLE;
          end else begin
            finish_r <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.Address     = addr_r;
  assign bus.data        = data_r;
  assign bus.wren        = wren_r;
  assign bus.Init_Finish = finish_r;

endmodule

// File: tb/tb_fsm_shuffler.sv
// Directed bench for fsm_shuffler with a behavioural S-box RAM and software KSA reference.
module tb_fsm_shuffler;
  import rc4_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic ram_init;

  always #5 clk = ~clk;

  fsm_shuffler_if bus ();

  fsm_shuffler dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [7:0]  mem [256];
  logic [7:0]  exp_s [256];
  logic [15:0] wlog [$];
  int          wren_cnt = 0;
  int          stray_cnt = 0;
  int          n_checks = 0;
  int          n_errors = 0;

  always @(posedge clk) begin
    if (ram_init) begin
      for (int k = 0; k < 256; k++) mem[k] <= 8'(k);
    end else if (bus.wren) begin
      mem[bus.Address] <= bus.data;
    end
    bus.q <= mem[bus.Address];
  end

  always @(posedge clk) begin
    if (bus.wren) begin
      wlog.push_back({bus.Address, bus.data});
      wren_cnt++;
      if (bus.Init_Finish) stray_cnt++;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic ksa_model(input logic [23:0] key);
    logic [7:0] jj, t, kb;
    for (int k = 0; k < 256; k++) exp_s[k] = 8'(k);
    jj = 8'd0;
    for (int k = 0; k < 256; k++) begin
      case (k % 3)
        0:       kb = key[23:16];
        1:       kb = key[15:8];
        default: kb = key[7:0];
      endcase
      jj = jj + exp_s[k] + kb;
      t = exp_s[k];
      exp_s[k] = exp_s[jj];
      exp_s[jj] = t;
    end
  endtask

  task automatic load_ram();
    ram_init = 1'b1;
    @(negedge clk);
    ram_init = 1'b0;
  endtask

  task automatic pulse_start();
    bus.In_Start = 1'b1;
    @(negedge clk);
    bus.In_Start = 1'b0;
  endtask

  task automatic wait_finish(output int cyc);
    cyc = 0;
    while (!bus.Init_Finish && cyc < 3000) begin
      @(negedge clk);
      cyc++;
    end
    check("finish_in_budget", 32'(cyc < 3000), 32'd1);
  endtask

  task automatic check_ram(input string tag, input logic [23:0] key);
    int nmis, ndup;
    logic [255:0] seen;
    ksa_model(key);
    nmis = 0;
    ndup = 0;
    seen = '0;
    for (int k = 0; k < 256; k++) begin
      if (mem[k] !== exp_s[k]) nmis++;
      if (seen[mem[k]]) ndup++;
      seen[mem[k]] = 1'b1;
    end
    check({tag, "_ksa_mismatches"}, 32'(nmis), 32'd0);
    check({tag, "_perm_dups"}, 32'(ndup), 32'd0);
  endtask

  task automatic ack_finish();
    bus.Finish_ack = 1'b1;
    @(negedge clk);
    bus.Finish_ack = 1'b0;
    check("finish_cleared", 32'(bus.Init_Finish), 32'd0);
  endtask

  initial begin
    int base, wbase, cyc;

    rst = 1'b1;
    ram_init = 1'b0;
    bus.In_Start = 1'b0;
    bus.Finish_ack = 1'b0;
    bus.Secret_Key = 24'hCAFEB0;
    load_ram();
    @(negedge clk);
    check("rst_wren", 32'(bus.wren), 32'd0);
    check("rst_finish", 32'(bus.Init_Finish), 32'd0);
    check("rst_addr", 32'(bus.Address), 32'd0);
    check("rst_data", 32'(bus.data), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Key CAFEB0: first iterations and full run
    base = wlog.size();
    wbase = wren_cnt;
    pulse_start();
    wait_finish(cyc);
    check("finish_latency_ok", 32'(cyc >= 2302 && cyc <= 2306), 32'd1);
    check("wren_count", 32'(wren_cnt - wbase), 32'd512);
    check("it0_wr_i", 32'(wlog[base + 0]), 32'h00CA);
    check("it0_wr_j", 32'(wlog[base + 1]), 32'hCA00);
    check("it1_wr_i", 32'(wlog[base + 2]), 32'h01C9);
    check("it1_wr_j", 32'(wlog[base + 3]), 32'hC901);
    check("it2_wr_i", 32'(wlog[base + 4]), 32'h027B);
    check("it2_wr_j", 32'(wlog[base + 5]), 32'h7B02);
    check_ram("cafeb0", 24'hCAFEB0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("finish_held", 32'(bus.Init_Finish), 32'd1);
    end
    check("no_wren_in_done", 32'(stray_cnt), 32'd0);
    ack_finish();
    wbase = wren_cnt;
    repeat (12) @(negedge clk);
    check("idle_no_wren", 32'(wren_cnt - wbase), 32'd0);
    check("idle_finish_low", 32'(bus.Init_Finish), 32'd0);

    // Zero key: i==j at i=0 leaves S[0] untouched
    bus.Secret_Key = 24'h000000;
    load_ram();
    base = wlog.size();
    wbase = wren_cnt;
    pulse_start();
    wait_finish(cyc);
    check("zk_it0_wr_i", 32'(wlog[base + 0]), 32'h0000);
    check("zk_it0_wr_j", 32'(wlog[base + 1]), 32'h0000);
    check("zk_wren_count", 32'(wren_cnt - wbase), 32'd512);
    check_ram("zero", 24'h000000);
    check("zk_no_wren_in_done", 32'(stray_cnt), 32'd0);
    ack_finish();

    // Reset mid-run around i=40, then a fresh run
    bus.Secret_Key = 24'hCAFEB0;
    load_ram();
    wbase = wren_cnt;
    pulse_start();
    repeat (40 * 9 + 4) @(negedge clk);
    check("midrun_writes_seen", 32'(wren_cnt - wbase > 70), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_wren", 32'(bus.wren), 32'd0);
    check("abort_addr", 32'(bus.Address), 32'd0);
    check("abort_finish", 32'(bus.Init_Finish), 32'd0);
    wbase = wren_cnt;
    repeat (15) @(negedge clk);
    check("abort_idle_no_wren", 32'(wren_cnt - wbase), 32'd0);
    load_ram();
    base = wlog.size();
    pulse_start();
    wait_finish(cyc);
    check("rerun_it0_wr_i", 32'(wlog[base + 0]), 32'h00CA);
    check("rerun_it0_wr_j", 32'(wlog[base + 1]), 32'hCA00);
    check("rerun_it1_wr_i", 32'(wlog[base + 2]), 32'h01C9);
    check("rerun_latency_ok", 32'(cyc >= 2302 && cyc <= 2306), 32'd1);
    check_ram("rerun", 24'hCAFEB0);
    ack_finish();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
